// File: rtl/alu_share_seq_pkg.sv
// Shared opcode, FSM state and nibble-width definitions for the shared nibble ALU.
package alu_share_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit ALU slice; carry-out is only produced by ADD.
module alu_nibble
  import alu_share_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [NIB_W-1:0] y,
  output logic             co
);

  always_comb begin
    y  = '0;
    co = 1'b0;
    case (op_e'(op))
      OP_ADD:  {co, y} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = ~a;
    endcase
  end

endmodule

// File: rtl/alu_share_seq.sv
// Two-requester round-robin front end executing 8-bit ops nibble-serially on one slice.
// Optional signed-overflow output enabled by defining ALU_OVF_FLAG_EN.
module alu_share_seq
  import alu_share_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [1:0]   op0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [1:0]   op1,
  input  logic         cin1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         cout
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  state_e           state, state_d;
  logic             last_grant, gnt_q, win, any_req;
  logic [W-1:0]     a_q, b_q;
  op_e              op_q;
  logic             cin_q;
  logic [NIB_W-1:0] lo_q;
  logic             c4_q;
  logic [NIB_W-1:0] nib_a, nib_b, nib_y;
  logic             nib_cin, nib_co;

  always_comb begin
    any_req = req0 | req1;
    // On contention the requester that did not win last time gets the slot
    win     = (req0 & req1) ? ~last_grant : req1;
    state_d = state;
    case (state)
      S_IDLE:  if (any_req) state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nib_a   = a_q[NIB_W-1:0];
    nib_b   = b_q[NIB_W-1:0];
    nib_cin = cin_q;
    if (state == S_HI) begin
      nib_a   = a_q[W-1:NIB_W];
      nib_b   = b_q[W-1:NIB_W];
      nib_cin = c4_q;
    end
  end

  alu_nibble u_nibble (
    .a   (nib_a),
    .b   (nib_b),
    .cin (nib_cin),
    .op  (op_q),
    .y   (nib_y),
    .co  (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      cin_q      <= 1'b0;
      lo_q       <= '0;
      c4_q       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result     <= '0;
      cout       <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ovf        <= 1'b0;
`endif
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: if (any_req) begin
          gnt_q      <= win;
          last_grant <= win;
          a_q        <= win ? a1 : a0;
          b_q        <= win ? b1 : b0;
          op_q       <= op_e'(win ? op1 : op0);
          cin_q      <= win ? cin1 : cin0;
          ack0       <= ~win;
          ack1       <= win;
        end
        S_LO: begin
          lo_q <= nib_y;
          c4_q <= nib_co;
        end
        S_HI: begin
          result <= {nib_y, lo_q};
          cout   <= nib_co;
          done0  <= ~gnt_q;
          done1  <= gnt_q;
`ifdef ALU_OVF_FLAG_EN
          ovf    <= (op_q == OP_ADD) && (a_q[W-1] == b_q[W-1]) &&
                    (nib_y[NIB_W-1] != a_q[W-1]);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_seq.sv
// Scoreboard bench for alu_share_seq: expected results queued at drive time, checked on done.
module tb_alu_share_seq;

  localparam logic [1:0] ADD = 2'b00, AND_OP = 2'b01, XOR_OP = 2'b10, NOT_OP = 2'b11;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, cin0, cin1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic       ack0, ack1, done0, done1, cout;
  logic [7:0] result;
`ifdef ALU_OVF_FLAG_EN
  logic       ovf;
`endif

  exp_t sb[$];
  int   nchk  = 0;
  int   nfail = 0;

  alu_share_seq #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .op0    (op0),
    .cin0   (cin0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .op1    (op1),
    .cin1   (cin1),
    .ack0   (ack0),
    .ack1   (ack1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .cout   (cout)
`ifdef ALU_OVF_FLAG_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] op, input logic cin);
    exp_t       e;
    logic [8:0] s;
    e.id = id;
    e.co = 1'b0;
    e.ov = 1'b0;
    case (op)
      ADD: begin
        s    = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        e.res = s[7:0];
        e.co  = s[8];
        e.ov  = (a[7] == b[7]) && (s[7] != a[7]);
      end
      AND_OP:  e.res = a & b;
      XOR_OP:  e.res = a ^ b;
      default: e.res = ~a;
    endcase
    return e;
  endfunction

  // Scoreboard consumer: every done must match the oldest outstanding operation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done0 || done1)) begin
      if (sb.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL unexpected_done: done0=%b done1=%b result=%h with nothing outstanding",
                 done0, done1, result);
      end else begin
        e = sb.pop_front();
        nchk++;
        if ({done0, done1} !== {~e.id, e.id}) begin
          nfail++;
          $display("FAIL done_owner: got done0/done1=%b%b expected %b%b", done0, done1, ~e.id, e.id);
        end
        nchk++;
        if (result !== e.res) begin
          nfail++;
          $display("FAIL result: got %h expected %h", result, e.res);
        end
        nchk++;
        if (cout !== e.co) begin
          nfail++;
          $display("FAIL cout: got %b expected %b", cout, e.co);
        end
`ifdef ALU_OVF_FLAG_EN
        nchk++;
        if (ovf !== e.ov) begin
          nfail++;
          $display("FAIL ovf: got %b expected %b", ovf, e.ov);
        end
`endif
      end
    end
  end

  task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic cin, input bit push);
    if (!id) begin
      req0 = 1'b1; a0 = a; b0 = b; op0 = op; cin0 = cin;
    end else begin
      req1 = 1'b1; a1 = a; b1 = b; op1 = op; cin1 = cin;
    end
    if (push) sb.push_back(model(id, a, b, op, cin));
  endtask

  // Called just after a posedge with a request pending; returns at posedge+1 after DONE.
  task automatic wait_op(output int lat, output logic ak0, output logic ak1, input bit drop);
    lat = 0; ak0 = 1'b0; ak1 = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ak0 = ack0; ak1 = ack1;
        if (drop) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 || done1) begin lat = k; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    op0 = '0; op1 = '0; cin0 = 0; cin1 = 0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if ({ack0, ack1, done0, done1, result, cout} !== 13'b0) begin
      nfail++;
      $display("FAIL reset_outputs: got ack=%b%b done=%b%b result=%h cout=%b required all 0",
               ack0, ack1, done0, done1, result, cout);
    end
`ifdef ALU_OVF_FLAG_EN
    nchk++;
    if (ovf !== 1'b0) begin nfail++; $display("FAIL reset_ovf: got %b required 0", ovf); end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_req0_only;
    int lat; logic k0, k1;
    drive(1'b0, 8'h3C, 8'h0F, ADD, 1'b0, 1'b1);
    wait_op(lat, k0, k1, 1'b1);
    nchk++;
    if ({k0, k1} !== 2'b10) begin nfail++; $display("FAIL req0_ack: got ack0/ack1=%b%b required 10", k0, k1); end
    nchk++;
    if (lat !== 3) begin nfail++; $display("FAIL req0_latency: got %0d cycles required 3", lat); end
  endtask

  task automatic test_req1_only;
    int lat; logic k0, k1;
    drive(1'b1, 8'hFF, 8'h01, ADD, 1'b1, 1'b1);
    wait_op(lat, k0, k1, 1'b1);
    nchk++;
    if ({k0, k1} !== 2'b01) begin nfail++; $display("FAIL req1_ack: got ack0/ack1=%b%b required 01", k0, k1); end
    nchk++;
    if (lat !== 3) begin nfail++; $display("FAIL req1_latency: got %0d cycles required 3", lat); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] order;
    int nack, ndone;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    a0 = 8'hAA; b0 = 8'h55; op0 = XOR_OP; cin0 = 0;
    a1 = 8'h0F; b1 = 8'h33; op1 = XOR_OP; cin1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back(i % 2 == 0 ? model(1'b0, a0, b0, op0, cin0) : model(1'b1, a1, b1, op1, cin1));
    @(negedge clk) rst_n = 1'b1;
    order = '0; nack = 0; ndone = 0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        if (nack < 4) order[nack] = ack1;
        nack++;
        if (nack == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 || done1) ndone++;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (order[i] !== i[0]) begin
        nfail++;
        $display("FAIL alternate_grant%0d: got requester %b required %b", i, order[i], i[0]);
      end
    end
    nchk++;
    if (ndone !== 4) begin nfail++; $display("FAIL alternate_done_count: got %0d required 4", ndone); end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf;
    int lat; logic k0, k1;
    drive(1'b0, 8'h70, 8'h10, ADD, 1'b0, 1'b1);
    wait_op(lat, k0, k1, 1'b1);
    nchk++;
    if (lat !== 3) begin nfail++; $display("FAIL ovf_add_latency: got %0d required 3", lat); end
    drive(1'b0, 8'h0F, 8'hA5, NOT_OP, 1'b1, 1'b1);
    wait_op(lat, k0, k1, 1'b1);
    nchk++;
    if (lat !== 3) begin nfail++; $display("FAIL not_latency: got %0d required 3", lat); end
  endtask

  task automatic test_reset_mid_op;
    int nd; int lat; logic k0, k1;
    drive(1'b0, 8'h12, 8'h34, ADD, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({ack0, ack1, done0, done1, result, cout} !== 13'b0) begin
      nfail++;
      $display("FAIL async_reset: got ack=%b%b done=%b%b result=%h cout=%b required all 0",
               ack0, ack1, done0, done1, result, cout);
    end
    req0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done0 || done1) nd++;
    end
    nchk++;
    if (nd !== 0) begin nfail++; $display("FAIL discarded_op_done: got %0d dones required 0", nd); end
    @(posedge clk); #1;
    drive(1'b1, 8'h40, 8'h04, AND_OP, 1'b0, 1'b0);
    drive(1'b0, 8'h12, 8'h34, ADD, 1'b0, 1'b1);
    wait_op(lat, k0, k1, 1'b1);
    nchk++;
    if ({k0, k1} !== 2'b10) begin nfail++; $display("FAIL post_reset_winner: got ack0/ack1=%b%b required 10", k0, k1); end
  endtask

  task automatic test_pulse_and_capture;
    int na; int lat;
    drive(1'b1, 8'hF0, 8'h3C, AND_OP, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    nchk++;
    if (ack1 !== 1'b1) begin nfail++; $display("FAIL busy_ack1: got %b required 1", ack1); end
    req1 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; a0 = 8'h99; b0 = 8'h66; op0 = ADD; cin0 = 0;
    @(posedge clk); #1;
    req0 = 1'b0;
    na = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack0) na++;
    end
    nchk++;
    if (na !== 0) begin nfail++; $display("FAIL pulsed_req_acked: got %0d acks required 0", na); end
    @(posedge clk); #1;
    drive(1'b0, 8'h21, 8'h13, ADD, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    nchk++;
    if (ack0 !== 1'b1) begin nfail++; $display("FAIL capture_ack0: got %b required 1", ack0); end
    a0 = 8'hFF; b0 = 8'hFF; op0 = NOT_OP; cin0 = 1'b0; req0 = 1'b0;
    lat = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (done0 || done1) begin lat = k; break; end
    end
    nchk++;
    if (lat !== 3) begin nfail++; $display("FAIL capture_latency: got %0d required 3", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_req0_only;
    test_req1_only;
    test_back_to_back;
    test_ovf;
    test_reset_mid_op;
    test_pulse_and_capture;
    repeat (2) @(posedge clk);
    nchk++;
    if (sb.size() !== 0) begin
      nfail++;
      $display("FAIL outstanding_ops: got %0d still pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
